// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity and per-frame error pulses
module uart_rx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Rx_in,
    input  logic [5:0]       Prescale,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic [width-1:0] P_Data,
    output logic             Data_valid,
    output logic             Parity_error,
    output logic             Stop_error
);
    localparam int BW = (width > 1) ? $clog2(width) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [5:0]       edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [5:0]       presc_q, presc_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic [2:0]       samp_q, samp_d;
    logic [width-1:0] shreg_q, shreg_d;
    logic             perr_q, perr_d;
    logic [width-1:0] pdata_q, pdata_d;
    logic             dv_q, dv_d;
    logic             pe_q, pe_d;
    logic             se_q, se_d;

    logic       rx_s, bit_val, last, go;
    logic [5:0] half;

    assign rx_s    = sync_q[1];
    assign half    = presc_q >> 1;
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
    assign last    = (state_q != IDLE) && (edge_cnt_q == presc_q - 6'd1);
    // A start is taken from IDLE, or in the final STOP cycle so back-to-back frames lose no cycle
    assign go      = !rx_s && (state_q == IDLE || (state_q == STOP && last));

    // Next-state, bit timing, majority sampling and output pulse generation
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[0], Rx_in};
        edge_cnt_d = (state_q == IDLE) ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;
        if (edge_cnt_q == half - 6'd1) samp_d[0] = rx_s;
        if (edge_cnt_q == half) samp_d[1] = rx_s;
        if (edge_cnt_q == half + 6'd1) samp_d[2] = rx_s;
        if (last) begin
            edge_cnt_d = 6'd0;
            case (state_q)
                START: begin
                    state_d   = bit_val ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shreg_d   = {bit_val, shreg_q[width-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(width - 1)) state_d = par_en_q ? PARITY : STOP;
                end
                PARITY: begin
                    perr_d  = bit_val != (par_type_q ? ~^shreg_q : ^shreg_q);
                    state_d = STOP;
                end
                STOP: begin
                    dv_d    = !perr_q && bit_val;
                    pe_d    = perr_q;
                    se_d    = !bit_val;
                    pdata_d = (!perr_q && bit_val) ? shreg_q : pdata_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        if (go) begin
            state_d    = START;
            edge_cnt_d = 6'd0;
            bit_cnt_d  = '0;
            presc_d    = Prescale;
            par_en_d   = Parity_EN;
            par_type_d = Parity_type;
            perr_d     = 1'b0;
        end
    end

    // State register with synchronous reset; a partial frame is discarded on reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            presc_q    <= 6'd16;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            samp_q     <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_Data       = pdata_q;
    assign Data_valid   = dv_q;
    assign Parity_error = pe_q;
    assign Stop_error   = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model and per-cycle output check for uart_rx
module tb_uart_rx;
    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       Rx_in = 1'b1;
    logic [5:0] Prescale = 6'd16;
    logic       Parity_EN = 1'b0;
    logic       Parity_type = 1'b0;
    logic [7:0] P_Data;
    logic       Data_valid, Parity_error, Stop_error;

    uart_rx #(.width(8)) dut (
        .CLK(CLK), .Reset(Reset), .Rx_in(Rx_in), .Prescale(Prescale),
        .Parity_EN(Parity_EN), .Parity_type(Parity_type), .P_Data(P_Data),
        .Data_valid(Data_valid), .Parity_error(Parity_error), .Stop_error(Stop_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        log_q[$];
    logic [7:0] model_pdata = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;
    bit         chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // Every cycle: outputs must be idle except at the model's predicted pulse cycles
    always @(negedge CLK) begin
        if (chk_en) begin
            ev_t e;
            while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
                check("pulse_missed", cyc, exp_q[0].at);
                void'(exp_q.pop_front());
            end
            e = '{cyc, 1'b0, 1'b0, 1'b0, 8'h00};
            if (exp_q.size() != 0 && exp_q[0].at == cyc) e = exp_q.pop_front();
            if (e.dv) model_pdata = e.data;
            check("data_valid", Data_valid, e.dv);
            check("parity_error", Parity_error, e.pe);
            check("stop_error", Stop_error, e.se);
            check("p_data", P_Data, model_pdata);
            if (Data_valid || Parity_error || Stop_error)
                log_q.push_back('{cyc, Data_valid, Parity_error, Stop_error, P_Data});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        Rx_in = 1'b1;
        repeat (n) step();
    endtask

    // Drives one frame bit-exact at p cycles per bit; e0 is the first edge that samples the start bit
    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptype,
                              input bit bad_par, input bit stop_v, input bit flips,
                              input bit scramble, input int abort_bit, output int e0);
        logic bits[$];
        logic v;
        int   n;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back((ptype ? ~^d : ^d) ^ bad_par);
        bits.push_back(stop_v);
        n = bits.size();
        Prescale = p[5:0];
        Parity_EN = pen;
        Parity_type = ptype;
        e0 = cyc + 1;
        exp_q.push_back('{e0 + 2 + n * p, !(pen && bad_par) && stop_v, pen && bad_par, !stop_v, d});
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < p; c++) begin
                if (j == abort_bit && c == p / 2) begin
                    Reset = 1'b1;
                    Rx_in = 1'b1;
                    step();
                    Reset = 1'b0;
                    exp_q.delete();
                    model_pdata = 8'h00;
                    check("reset_p_data", P_Data, 8'h00);
                    check("reset_valid", Data_valid, 1'b0);
                    check("reset_errors", {Parity_error, Stop_error}, 2'b00);
                    return;
                end
                v = bits[j];
                if (flips && j >= 1 && j <= 8 && c == p / 2 + 1) v = ~v;
                if (scramble && j == 1 && c == 0) begin
                    Prescale = 6'($urandom_range(0, 63));
                    Parity_EN = 1'($urandom_range(0, 1));
                    Parity_type = 1'($urandom_range(0, 1));
                end
                Rx_in = v;
                step();
            end
        end
        Rx_in = 1'b1;
    endtask

    task automatic pin(input string n, input int at, input bit dv, input bit pe, input bit se,
                       input logic [7:0] d);
        check({n, "_seen"}, log_q.size() != 0, 1);
        if (log_q.size() != 0) begin
            check({n, "_cycle"}, log_q[$].at, at);
            check({n, "_flags"}, {log_q[$].dv, log_q[$].pe, log_q[$].se}, {dv, pe, se});
            check({n, "_data"}, log_q[$].data, d);
        end
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog at cycle %0d: bench did not finish, expected completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int e0, e1, n0;
        repeat (4) step();
        check("rst_p_data", P_Data, 8'h00);
        check("rst_flags", {Data_valid, Parity_error, Stop_error}, 3'b000);
        Reset = 1'b0;
        idle(4);
        chk_en = 1'b1;

        send_frame(8'hA5, 16, 0, 0, 0, 1, 0, 0, -1, e0);
        idle(8);
        pin("a5_p16", e0 + 162, 1, 0, 0, 8'hA5);

        send_frame(8'h3C, 8, 1, 0, 0, 1, 0, 0, -1, e0);
        idle(8);
        pin("3c_even_ok", e0 + 90, 1, 0, 0, 8'h3C);
        send_frame(8'h3C, 8, 1, 0, 1, 1, 0, 0, -1, e0);
        idle(8);
        pin("3c_even_bad", e0 + 90, 0, 1, 0, 8'h3C);

        send_frame(8'h81, 32, 0, 0, 0, 0, 0, 0, -1, e0);
        idle(8);
        pin("81_stop_err", e0 + 322, 0, 0, 1, 8'h3C);
        send_frame(8'h7E, 32, 0, 0, 0, 1, 0, 0, -1, e0);
        idle(8);
        pin("7e_after_err", e0 + 322, 1, 0, 0, 8'h7E);

        n0 = log_q.size();
        Prescale = 6'd16;
        Parity_EN = 1'b0;
        Rx_in = 1'b0;
        repeat (4) step();
        idle(30);
        check("glitch_no_pulse", log_q.size(), n0);
        send_frame(8'h55, 16, 0, 0, 0, 1, 0, 0, -1, e0);
        idle(8);
        pin("55_after_glitch", e0 + 162, 1, 0, 0, 8'h55);

        send_frame(8'hC3, 16, 0, 0, 0, 1, 1, 0, -1, e0);
        idle(8);
        pin("c3_flipped", e0 + 162, 1, 0, 0, 8'hC3);

        send_frame(8'h01, 16, 0, 0, 0, 1, 0, 0, -1, e0);
        send_frame(8'hFE, 16, 0, 0, 0, 1, 0, 0, -1, e1);
        idle(8);
        check("b2b_start_gap", e1 - e0, 160);
        pin("fe_b2b", e0 + 322, 1, 0, 0, 8'hFE);
        check("b2b_pulse_gap", log_q.size() >= 2 ? log_q[$].at - log_q[$-1].at : 0, 160);

        n0 = log_q.size();
        send_frame(8'hE7, 16, 0, 0, 0, 1, 0, 0, 4, e0);
        idle(200);
        check("abort_no_pulse", log_q.size(), n0);
        send_frame(8'h96, 16, 0, 0, 0, 1, 0, 0, -1, e0);
        idle(8);
        pin("96_after_reset", e0 + 162, 1, 0, 0, 8'h96);

        for (int k = 0; k < 30; k++) begin
            send_frame(8'($urandom), 8 << $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                       $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), -1, e0);
            idle($urandom_range(0, 4));
        end
        idle(12);
        check("all_pulses_seen", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
